// File: rtl/ccip_if_pkg.sv
// Subset of the CCI-P interface types used by the DMA read engine: the c0
// read-request header and channel, and the c0 response header and channel.
package ccip_if_pkg;

    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

endpackage

// File: rtl/dma_rd_pkg.sv
// Shared state type, widths and helpers for the DMA read engine.
package dma_rd_pkg;

    localparam int ADDR_W = 42;
    localparam int LEN_W  = 16;
    localparam int DATA_W = 512;
    localparam int BUF_W  = DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } t_dma_rd_state;

    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/dma_rd_fifo.sv
// Show-ahead synchronous FIFO holding returned lines plus their last flag.
module dma_rd_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 513
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wrEn,
    input  logic [WIDTH-1:0]       i_wrData,
    input  logic                   i_rdEn,
    output logic [WIDTH-1:0]       o_rdData,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;

    assign w_pop = i_rdEn && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    // Clearing the pointers and count empties the buffer; stale array contents are never visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_wrEn) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({i_wrEn, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdData = r_mem[r_rdPtr];
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;

    a_noOverflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_wrEn && (r_count == (PTR_W+1)'(DEPTH))));

endmodule

// File: rtl/dma_rd_engine.sv
// Descriptor-driven CCI-P line reader: issues RDLINE requests, buffers in-order
// responses and streams them out. Define DMA_RD_PERF_CNT_EN to add perf counters.
module dma_rd_engine
    import ccip_if_pkg::*;
    import dma_rd_pkg::*;
#(
    parameter int BUF_DEPTH = 64,
    parameter int MDATA_W   = 9
) (
    input  logic               pClk,
    input  logic               SoftReset_n,
    input  logic               desc_valid,
    output logic               desc_ready,
    input  logic [ADDR_W-1:0]  desc_addr,
    input  logic [LEN_W-1:0]   desc_len,
    output t_if_ccip_c0_Tx     c0Tx,
    input  logic               c0TxAlmFull,
    input  t_if_ccip_c0_Rx     c0Rx,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [DATA_W-1:0]  dout_data,
    output logic               dout_last,
    output logic               done,
    output logic               busy,
    output logic               err_unexp_rsp
`ifdef DMA_RD_PERF_CNT_EN
    ,
    output logic [31:0]        perf_busy_cyc,
    output logic [31:0]        perf_almfull_stall
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    t_dma_rd_state      r_state;
    t_dma_rd_state      w_nextState;
    logic               r_rstDone;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issueCnt;
    logic [LEN_W-1:0]   r_rspCnt;
    logic [CNT_W-1:0]   r_outstanding;
    logic               r_txValid;
    logic [ADDR_W-1:0]  r_txAddr;
    logic [MDATA_W-1:0] r_txMdata;
    logic               r_wrValid;
    logic [DATA_W-1:0]  r_wrData;
    logic               r_wrLast;
    logic               r_err;

    logic               w_accept;
    logic               w_credit;
    logic               w_issue;
    logic               w_issueLast;
    logic               w_rspRd;
    logic               w_rspOk;
    logic               w_pop;
    logic [CNT_W:0]     w_inUse;
    logic [BUF_W-1:0]   w_fifoRdData;
    logic               w_fifoEmpty;
    logic [CNT_W-1:0]   w_fifoCount;
    logic               w_unused;

    assign w_accept = desc_valid && desc_ready;
    assign w_rspRd  = c0Rx.rspValid && (c0Rx.hdr.resp_type == eRSP_RDLINE);
    assign w_rspOk  = w_rspRd && (r_outstanding != '0);
    assign w_pop    = dout_valid && dout_ready;
    assign w_unused = ^c0Rx;

    // A line in the write pipeline stage is neither outstanding nor in the buffer, so reserve it too.
    assign w_inUse     = {1'b0, r_outstanding} + {1'b0, w_fifoCount} + {{CNT_W{1'b0}}, r_wrValid};
    assign w_credit    = (w_inUse < (CNT_W+1)'(BUF_DEPTH));
    assign w_issue     = (r_state == S_ISSUE) && !c0TxAlmFull && w_credit;
    assign w_issueLast = w_issue && (r_issueCnt == r_len - LEN_W'(1));

    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = (desc_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_issueLast) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && dout_last) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    assign desc_ready    = (r_state == S_IDLE) && r_rstDone;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign err_unexp_rsp = r_err;

    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_rstDone     <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_issueCnt    <= '0;
            r_rspCnt      <= '0;
            r_outstanding <= '0;
            r_txValid     <= 1'b0;
            r_txAddr      <= '0;
            r_txMdata     <= '0;
            r_wrValid     <= 1'b0;
            r_wrData      <= '0;
            r_wrLast      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_rstDone <= 1'b1;
            r_txValid <= w_issue;
            r_wrValid <= w_rspOk;
            if (w_issue) begin
                r_txAddr   <= r_addr + ADDR_W'(r_issueCnt);
                r_txMdata  <= r_issueCnt[MDATA_W-1:0];
                r_issueCnt <= r_issueCnt + LEN_W'(1);
            end
            // MPF returns lines in order, so the response count identifies the final line.
            if (w_rspOk) begin
                r_wrData <= c0Rx.data;
                r_wrLast <= (r_rspCnt == r_len - LEN_W'(1));
                r_rspCnt <= r_rspCnt + LEN_W'(1);
            end
            case ({w_issue, w_rspOk})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_rspRd && (r_outstanding == '0)) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_addr     <= desc_addr;
                r_len      <= desc_len;
                r_issueCnt <= '0;
                r_rspCnt   <= '0;
            end
        end
    end

    always_comb begin
        c0Tx              = '0;
        c0Tx.valid        = r_txValid;
        c0Tx.hdr.vc_sel   = eVC_VA;
        c0Tx.hdr.cl_len   = eCL_LEN_1;
        c0Tx.hdr.req_type = eREQ_RDLINE_I;
        c0Tx.hdr.address  = r_txAddr;
        c0Tx.hdr.mdata    = 16'(r_txMdata);
    end

    dma_rd_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (BUF_W)
    ) u_fifo (
        .i_clk    (pClk),
        .i_rst_n  (SoftReset_n),
        .i_wrEn   (r_wrValid),
        .i_wrData ({r_wrLast, r_wrData}),
        .i_rdEn   (dout_ready),
        .o_rdData (w_fifoRdData),
        .o_empty  (w_fifoEmpty),
        .o_count  (w_fifoCount)
    );

    assign dout_valid = !w_fifoEmpty;
    assign dout_data  = w_fifoRdData[DATA_W-1:0];
    assign dout_last  = dout_valid && w_fifoRdData[DATA_W];

`ifdef DMA_RD_PERF_CNT_EN
    logic [31:0] r_perfBusyCyc;
    logic [31:0] r_perfAlmStall;
    logic        w_almStall;

    // A stall is charged only when buffer credit was available and almost-full alone blocked the issue.
    assign w_almStall = (r_state == S_ISSUE) && c0TxAlmFull && w_credit;

    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            r_perfBusyCyc  <= '0;
            r_perfAlmStall <= '0;
        end else begin
            if (busy) begin
                r_perfBusyCyc <= satInc(r_perfBusyCyc);
            end
            if (w_almStall) begin
                r_perfAlmStall <= satInc(r_perfAlmStall);
            end
        end
    end

    assign perf_busy_cyc      = r_perfBusyCyc;
    assign perf_almfull_stall = r_perfAlmStall;
`endif

endmodule

// File: tb/tb_dma_rd_engine.sv
// Scoreboard bench for dma_rd_engine: an in-order MPF model answers every read,
// expected requests and beats are queued at stimulus time and compared on output.
module tb_dma_rd_engine;
    import ccip_if_pkg::*;
    import dma_rd_pkg::*;

    typedef struct packed {
        logic [41:0]  addr;
        logic [8:0]   mdata;
        t_ccip_clLen  cl;
        t_ccip_vc     vc;
        t_ccip_c0_req rt;
    } reqRec_t;

    logic           pClk = 1'b0;
    logic           SoftReset_n = 1'b1;
    logic           desc_valid = 1'b0;
    logic           desc_ready;
    logic [41:0]    desc_addr = '0;
    logic [15:0]    desc_len = '0;
    t_if_ccip_c0_Tx c0Tx;
    logic           c0TxAlmFull = 1'b0;
    t_if_ccip_c0_Rx c0Rx = '0;
    logic           dout_valid;
    logic           dout_ready = 1'b1;
    logic [511:0]   dout_data;
    logic           dout_last;
    logic           done;
    logic           busy;
    logic           err_unexp_rsp;
`ifdef DMA_RD_PERF_CNT_EN
    logic [31:0]    perf_busy_cyc;
    logic [31:0]    perf_almfull_stall;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acceptCyc = 0;
    int lastAcceptCyc = 0;
    int doneCyc = 0;
    int doneCnt = 0;
    int busyCnt = 0;
    int rspBudget = -1;
    bit releaseHeld = 1'b0;
    bit sawDv = 1'b0;

    reqRec_t      expReq[$];
    reqRec_t      obsReq[$];
    logic [512:0] expBeat[$];
    logic [512:0] obsBeat[$];
    logic [41:0]  heldQ[$];

    dma_rd_engine #(
        .BUF_DEPTH (64),
        .MDATA_W   (9)
    ) dut (
        .pClk          (pClk),
        .SoftReset_n   (SoftReset_n),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_addr     (desc_addr),
        .desc_len      (desc_len),
        .c0Tx          (c0Tx),
        .c0TxAlmFull   (c0TxAlmFull),
        .c0Rx          (c0Rx),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .dout_data     (dout_data),
        .dout_last     (dout_last),
        .done          (done),
        .busy          (busy),
        .err_unexp_rsp (err_unexp_rsp)
`ifdef DMA_RD_PERF_CNT_EN
        ,
        .perf_busy_cyc      (perf_busy_cyc),
        .perf_almfull_stall (perf_almfull_stall)
`endif
    );

    always #5 pClk = ~pClk;

    always @(posedge pClk) cyc++;

    function automatic logic [511:0] mkData(input logic [41:0] a);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) begin
            d[k*32 +: 32] = a[31:0] ^ {a[41:32], 22'(k * 7 + 1)};
        end
        return d;
    endfunction

    // MPF model: answers each request on the following edge, or holds it when the budget is spent.
    always @(negedge pClk) begin
        c0Rx = '0;
        if (c0Tx.valid) begin
            obsReq.push_back('{addr: c0Tx.hdr.address, mdata: c0Tx.hdr.mdata[8:0],
                               cl: c0Tx.hdr.cl_len, vc: c0Tx.hdr.vc_sel, rt: c0Tx.hdr.req_type});
            if (rspBudget != 0) begin
                c0Rx.rspValid      = 1'b1;
                c0Rx.hdr.resp_type = eRSP_RDLINE;
                c0Rx.hdr.mdata     = c0Tx.hdr.mdata;
                c0Rx.data          = mkData(c0Tx.hdr.address);
                if (rspBudget > 0) rspBudget--;
            end else begin
                heldQ.push_back(c0Tx.hdr.address);
            end
        end else if (releaseHeld && heldQ.size() > 0) begin
            logic [41:0] ha;
            ha = heldQ.pop_front();
            c0Rx.rspValid      = 1'b1;
            c0Rx.hdr.resp_type = eRSP_RDLINE;
            c0Rx.data          = mkData(ha);
        end
    end

    always @(negedge pClk) begin
        if (dout_valid) sawDv = 1'b1;
        if (dout_valid && dout_ready) begin
            obsBeat.push_back({dout_last, dout_data});
            if (dout_last) lastAcceptCyc = cyc;
        end
        if (done) begin
            doneCnt++;
            doneCyc = cyc;
        end
        if (busy) busyCnt++;
    end

    task automatic pushExpected(input logic [41:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            logic [41:0] ai;
            ai = a + 42'(i);
            expReq.push_back('{addr: ai, mdata: 9'(i), cl: eCL_LEN_1, vc: eVC_VA, rt: eREQ_RDLINE_I});
            expBeat.push_back({(i == n - 1), mkData(ai)});
        end
    endtask

    task automatic applyStimulus(input logic [41:0] a, input logic [15:0] l);
        int n;
        desc_addr  = a;
        desc_len   = l;
        desc_valid = 1'b1;
        n = 0;
        do begin
            @(negedge pClk);
            n++;
        end while (!desc_ready && n < 100);
        acceptCyc = cyc;
        if (!desc_ready) begin
            checks++; errors++;
            $display("[TB] FAIL desc_accept timeout got=0 want=1");
        end
        @(posedge pClk);
        #1 desc_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 SoftReset_n = 1'b0;
        #1;
        checks++;
        if ({c0Tx.valid, desc_ready, dout_valid, dout_last, done, busy, err_unexp_rsp} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b want=0000000",
                     {c0Tx.valid, desc_ready, dout_valid, dout_last, done, busy, err_unexp_rsp});
        end
        repeat (3) @(posedge pClk);
        @(negedge pClk) SoftReset_n = 1'b1;
        #1;
        checks++;
        if (desc_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL ready_before_edge got=%b want=0", desc_ready);
        end
        @(posedge pClk);
        #1;
        checks++;
        if (desc_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL ready_after_reset got=%b want=1", desc_ready);
        end
    endtask

    task automatic test_basic();
        int d0, n;
        reqRec_t er, gr;
        logic [512:0] eb, gb;
        d0 = doneCnt;
        pushExpected(42'h100, 4);
        applyStimulus(42'h100, 16'd4);
        n = 0;
        while (doneCnt == d0 && n < 500) begin @(posedge pClk); n++; end
        repeat (2) @(posedge pClk);
        #1;
        while (expReq.size() > 0) begin
            er = expReq.pop_front();
            gr = (obsReq.size() > 0) ? obsReq.pop_front() : '0;
            checks++;
            if (gr !== er) begin errors++; $display("[TB] FAIL basic_req got=%h want=%h", gr, er); end
        end
        while (expBeat.size() > 0) begin
            eb = expBeat.pop_front();
            gb = (obsBeat.size() > 0) ? obsBeat.pop_front() : '0;
            checks++;
            if (gb !== eb) begin errors++; $display("[TB] FAIL basic_beat got_last=%b want_last=%b got=%h", gb[512], eb[512], gb[31:0]); end
        end
        checks++;
        if (obsReq.size() + obsBeat.size() != 0) begin
            errors++; $display("[TB] FAIL basic_extra got=%0d want=0", obsReq.size() + obsBeat.size());
        end
        checks++;
        if (doneCnt != d0 + 1) begin errors++; $display("[TB] FAIL basic_done_cnt got=%0d want=%0d", doneCnt - d0, 1); end
        checks++;
        if (doneCyc != lastAcceptCyc + 1) begin
            errors++; $display("[TB] FAIL basic_done_cycle got=%0d want=%0d", doneCyc, lastAcceptCyc + 1);
        end
    endtask

    task automatic test_zero_len();
        int d0;
        d0 = doneCnt;
        applyStimulus(42'h500, 16'd0);
        repeat (5) @(posedge pClk);
        #1;
        checks++;
        if (doneCnt != d0 + 1) begin errors++; $display("[TB] FAIL zero_done_cnt got=%0d want=1", doneCnt - d0); end
        checks++;
        if (doneCyc != acceptCyc + 1) begin
            errors++; $display("[TB] FAIL zero_done_cycle got=%0d want=%0d", doneCyc, acceptCyc + 1);
        end
        checks++;
        if (obsReq.size() != 0) begin errors++; $display("[TB] FAIL zero_reqs got=%0d want=0", obsReq.size()); end
        checks++;
        if (obsBeat.size() != 0) begin errors++; $display("[TB] FAIL zero_beats got=%0d want=0", obsBeat.size()); end
        obsReq.delete();
        obsBeat.delete();
    endtask

    task automatic test_almfull();
        int d0, n, b0;
        reqRec_t er, gr;
        logic [512:0] eb, gb;
`ifdef DMA_RD_PERF_CNT_EN
        logic [31:0] s0, p0;
        s0 = perf_almfull_stall;
        p0 = perf_busy_cyc;
`endif
        d0 = doneCnt;
        b0 = busyCnt;
        pushExpected(42'h2000, 8);
        c0TxAlmFull = 1'b1;
        applyStimulus(42'h2000, 16'd8);
        repeat (10) @(posedge pClk);
        #1;
        checks++;
        if (obsReq.size() != 0) begin errors++; $display("[TB] FAIL almfull_blocked got=%0d want=0", obsReq.size()); end
        c0TxAlmFull = 1'b0;
        n = 0;
        while (doneCnt == d0 && n < 500) begin @(posedge pClk); n++; end
        repeat (2) @(posedge pClk);
        #1;
        while (expReq.size() > 0) begin
            er = expReq.pop_front();
            gr = (obsReq.size() > 0) ? obsReq.pop_front() : '0;
            checks++;
            if (gr !== er) begin errors++; $display("[TB] FAIL almfull_req got=%h want=%h", gr, er); end
        end
        while (expBeat.size() > 0) begin
            eb = expBeat.pop_front();
            gb = (obsBeat.size() > 0) ? obsBeat.pop_front() : '0;
            checks++;
            if (gb !== eb) begin errors++; $display("[TB] FAIL almfull_beat got_last=%b want_last=%b got=%h", gb[512], eb[512], gb[31:0]); end
        end
        checks++;
        if (doneCnt != d0 + 1) begin errors++; $display("[TB] FAIL almfull_done got=%0d want=1", doneCnt - d0); end
`ifdef DMA_RD_PERF_CNT_EN
        checks++;
        if (perf_almfull_stall - s0 != 32'd10) begin
            errors++; $display("[TB] FAIL perf_stall got=%0d want=10", perf_almfull_stall - s0);
        end
        checks++;
        if (perf_busy_cyc - p0 != 32'(busyCnt - b0)) begin
            errors++; $display("[TB] FAIL perf_busy got=%0d want=%0d", perf_busy_cyc - p0, busyCnt - b0);
        end
`else
        b0 = busyCnt - b0;
`endif
    endtask

    task automatic test_back_to_back();
        int d0, n, held;
        reqRec_t er, gr;
        logic [512:0] eb, gb;
        d0 = doneCnt;
        dout_ready = 1'b0;
        pushExpected(42'h1000, 100);
        applyStimulus(42'h1000, 16'd100);
        repeat (150) @(posedge pClk);
        #1;
        held = obsReq.size();
        checks++;
        if (held != 64) begin errors++; $display("[TB] FAIL bp_issue_limit got=%0d want=64", held); end
        repeat (20) @(posedge pClk);
        #1;
        checks++;
        if (obsReq.size() != held) begin errors++; $display("[TB] FAIL bp_tx_idle got=%0d want=%0d", obsReq.size(), held); end
        checks++;
        if ({dout_valid, dout_last, dout_data} !== {2'b10, mkData(42'h1000)}) begin
            errors++; $display("[TB] FAIL bp_head got_v=%b got_l=%b got=%h", dout_valid, dout_last, dout_data[31:0]);
        end
        repeat (3) @(posedge pClk);
        #1;
        checks++;
        if ({dout_valid, dout_last, dout_data} !== {2'b10, mkData(42'h1000)}) begin
            errors++; $display("[TB] FAIL bp_hold got_v=%b got_l=%b got=%h", dout_valid, dout_last, dout_data[31:0]);
        end
        dout_ready = 1'b1;
        n = 0;
        while (doneCnt == d0 && n < 2000) begin @(posedge pClk); n++; end
        repeat (2) @(posedge pClk);
        #1;
        while (expReq.size() > 0) begin
            er = expReq.pop_front();
            gr = (obsReq.size() > 0) ? obsReq.pop_front() : '0;
            checks++;
            if (gr !== er) begin errors++; $display("[TB] FAIL bp_req got=%h want=%h", gr, er); end
        end
        while (expBeat.size() > 0) begin
            eb = expBeat.pop_front();
            gb = (obsBeat.size() > 0) ? obsBeat.pop_front() : '0;
            checks++;
            if (gb !== eb) begin errors++; $display("[TB] FAIL bp_beat got_last=%b want_last=%b got=%h", gb[512], eb[512], gb[31:0]); end
        end
        checks++;
        if (doneCnt != d0 + 1) begin errors++; $display("[TB] FAIL bp_done got=%0d want=1", doneCnt - d0); end
    endtask

    task automatic test_wrap();
        int d0, n;
        reqRec_t er, gr;
        logic [512:0] eb, gb;
        d0 = doneCnt;
        pushExpected(42'h3FF_FFFF_FFFE, 3);
        applyStimulus(42'h3FF_FFFF_FFFE, 16'd3);
        n = 0;
        while (doneCnt == d0 && n < 500) begin @(posedge pClk); n++; end
        repeat (2) @(posedge pClk);
        #1;
        while (expReq.size() > 0) begin
            er = expReq.pop_front();
            gr = (obsReq.size() > 0) ? obsReq.pop_front() : '0;
            checks++;
            if (gr !== er) begin errors++; $display("[TB] FAIL wrap_req got=%h want=%h", gr, er); end
        end
        while (expBeat.size() > 0) begin
            eb = expBeat.pop_front();
            gb = (obsBeat.size() > 0) ? obsBeat.pop_front() : '0;
            checks++;
            if (gb !== eb) begin errors++; $display("[TB] FAIL wrap_beat got_last=%b want_last=%b got=%h", gb[512], eb[512], gb[31:0]); end
        end
        checks++;
        if (doneCnt != d0 + 1) begin errors++; $display("[TB] FAIL wrap_done got=%0d want=1", doneCnt - d0); end
    endtask

    task automatic test_abort();
        int n;
        obsReq.delete();
        obsBeat.delete();
        dout_ready = 1'b0;
        rspBudget = 2;
        applyStimulus(42'h4000, 16'd6);
        n = 0;
        while (heldQ.size() < 4 && n < 100) begin @(posedge pClk); n++; end
        repeat (3) @(posedge pClk);
        #1;
        checks++;
        if (heldQ.size() != 4) begin errors++; $display("[TB] FAIL abort_held got=%0d want=4", heldQ.size()); end
        SoftReset_n = 1'b0;
        #1;
        checks++;
        if ({c0Tx.valid, desc_ready, dout_valid, dout_last, done, busy, err_unexp_rsp} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL abort_reset_outputs got=%b want=0000000",
                     {c0Tx.valid, desc_ready, dout_valid, dout_last, done, busy, err_unexp_rsp});
        end
        repeat (2) @(posedge pClk);
        @(negedge pClk) SoftReset_n = 1'b1;
        @(posedge pClk);
        #1;
        obsBeat.delete();
        sawDv = 1'b0;
        dout_ready = 1'b1;
        releaseHeld = 1'b1;
        n = 0;
        while (heldQ.size() > 0 && n < 100) begin @(posedge pClk); n++; end
        repeat (5) @(posedge pClk);
        #1;
        checks++;
        if (err_unexp_rsp !== 1'b1) begin errors++; $display("[TB] FAIL abort_err got=%b want=1", err_unexp_rsp); end
        checks++;
        if (sawDv || obsBeat.size() != 0) begin
            errors++; $display("[TB] FAIL abort_no_beats got=%0d/%b want=0/0", obsBeat.size(), sawDv);
        end
        checks++;
        if ({busy, desc_ready} !== 2'b01) begin errors++; $display("[TB] FAIL abort_idle got=%b want=01", {busy, desc_ready}); end
        releaseHeld = 1'b0;
        rspBudget = -1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_almfull();
        test_back_to_back();
        test_wrap();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dma_rd_engine.md
DMA_RD_ENGINE -- requirements
Module: dma_rd_engine

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 64, giving read-data buffer entries and the maximum number of reads in flight (power of 2, 4..512).
REQ-002 SHALL have parameter MDATA_W, default 9, giving the number of low Mdata bits carrying the line tag.
REQ-003 pClk  in  1  sole clock; every register on its rising edge.
REQ-004 SoftReset_n  in  1  asynchronous, active-low reset.
REQ-005 desc_valid / desc_ready  in / out  1 / 1  descriptor handshake.
REQ-006 desc_addr  in  42  start cache-line address (physical).
REQ-007 desc_len  in  16  number of lines to read.
REQ-008 c0Tx  out  t_if_ccip_c0_Tx  read-request channel toward MPF.
REQ-009 c0TxAlmFull  in  1  request backpressure.
REQ-010 c0Rx  in  t_if_ccip_c0_Rx  response channel from MPF; MPF sorts responses into order.
REQ-011 dout_valid / dout_ready  out / in  1 / 1  data stream handshake.
REQ-012 dout_data  out  512  line data.
REQ-013 dout_last  out  1  marks the final line of a descriptor.
REQ-014 done  out  1  one-cycle pulse when a descriptor completes.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 err_unexp_rsp  out  1  sticky flag for an unexpected read response.

Function
REQ-017 FSM states and transitions: IDLE -> ISSUE on descriptor accept with len>0; ISSUE -> DRAIN when the last request is issued; DRAIN -> DONE when the last line is accepted on dout; DONE -> IDLE after one cycle.
REQ-018 desc_ready SHALL be high only in IDLE; a descriptor is accepted when desc_valid and desc_ready are both high.
REQ-019 A descriptor with desc_len=0 SHALL pulse done in the cycle after acceptance, issue no reads and produce no dout beat.
REQ-020 In ISSUE, a request SHALL be issued in a cycle only when c0TxAlmFull=0 and (outstanding + buffer occupancy) < BUF_DEPTH.
REQ-021 c0Tx SHALL be registered; valid rises in the cycle after the issue qualification.
REQ-022 Request fields: address = desc_addr + i, modulo 2^42 (wraps); cl_len = eCL_LEN_1; vc_sel = eVC_VA; req_type = eREQ_RDLINE_I; mdata[MDATA_W-1:0] = i[MDATA_W-1:0].
REQ-023 A response counts only when it is a valid RDLINE response with outstanding>0; its data SHALL be written to the buffer in the next cycle.
REQ-024 A valid RDLINE response arriving with outstanding=0 SHALL be dropped and SHALL set err_unexp_rsp, which clears only on reset.
REQ-025 The outstanding counter SHALL increment on issue and decrement on a counted response; when both happen in the same cycle it SHALL be unchanged.
REQ-026 dout_valid SHALL rise one cycle after a buffer write at the earliest; dout_data and dout_last SHALL hold while dout_valid=1 and dout_ready=0.
REQ-027 dout_last=1 only on beat desc_len-1; done pulses in the cycle after that beat is accepted.
REQ-028 The buffer SHALL never overflow; a write to a full buffer is a design error and is covered by an assertion.

Reset
REQ-029 On SoftReset_n=0, state SHALL go to IDLE and all counters and the buffer SHALL clear.
REQ-030 During reset: c0Tx.valid=0, desc_ready=0, dout_valid=0, dout_last=0, done=0, busy=0, err_unexp_rsp=0.
REQ-031 desc_ready SHALL rise in the first cycle after reset deassertion.
REQ-032 Reset mid-operation SHALL abandon the descriptor; responses that arrive afterwards SHALL fall under REQ-024.

Configuration
REQ-033 With DMA_RD_PERF_CNT_EN defined, the block SHALL add outputs perf_busy_cyc[31:0] (counts cycles with busy=1) and perf_almfull_stall[31:0] (counts ISSUE cycles blocked only by c0TxAlmFull); both saturate at 0xFFFFFFFF and clear on reset.
REQ-034 Without DMA_RD_PERF_CNT_EN, neither port nor counter SHALL exist.

Structure
REQ-035 The state enum t_dma_rd_state and the width constants SHALL live in package dma_rd_pkg; the CCI-P types SHALL come from ccip_if_pkg.
REQ-036 The buffer SHALL be sub-module dma_rd_fifo: synchronous, show-ahead, depth BUF_DEPTH, width 513 (data + last).

Verification
REQ-037 Stimulus: addr=0x100, len=4, dout_ready=1, zero-latency MPF model. Response: exactly 4 reads to 0x100..0x103 with mdata 0..3, 4 beats, last on beat 3, one done pulse.
REQ-038 Stimulus: len=0. Response: done in the cycle after acceptance; no c0Tx.valid; no dout_valid.
REQ-039 Stimulus: c0TxAlmFull held high for 10 cycles during ISSUE of len=8. Response: no requests in those cycles; all 8 issued afterwards; perf_almfull_stall=10 when the macro is defined.
REQ-040 Stimulus: dout_ready=0, len=100, BUF_DEPTH=64. Response: issue stops at 64; c0Tx idle; then dout_ready=1 yields 100 ordered beats.
REQ-041 Stimulus: addr=0x3FF_FFFF_FFFE, len=3. Response: reads to 0x3FF_FFFF_FFFE, 0x3FF_FFFF_FFFF, 0x000_0000_0000.
REQ-042 Stimulus: reset asserted after 2 of 6 responses, then 4 stray responses. Response: outputs go to reset values; err_unexp_rsp=1; no dout beats.
